// File: rtl/mem_ncl_pkg.sv
// Shared types for the NCL RW-rail consumer: rail codes and controller state encoding.
package mem_ncl_pkg;

  typedef logic [1:0] rail_code_t;

  localparam rail_code_t RAIL_NULL    = 2'b00;
  localparam rail_code_t RAIL_DATA0   = 2'b01;
  localparam rail_code_t RAIL_DATA1   = 2'b10;
  localparam rail_code_t RAIL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDone  = 2'd2,
    StError = 2'd3
  } state_t;

endpackage

// File: rtl/dual_rail_sync.sv
// Per-rail flop synchronizer followed by a stability filter on the combined rail code.
module dual_rail_sync
  import mem_ncl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rail_t,
  input  logic       rail_f,
  output rail_code_t code,
  output logic       stable
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] t_sync_q, f_sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   changing;

  // The value entering the last stage differs from the one it holds: the count restarts.
  assign changing = {t_sync_q[SYNC_STAGES-2], f_sync_q[SYNC_STAGES-2]} !=
                    {t_sync_q[SYNC_STAGES-1], f_sync_q[SYNC_STAGES-1]};

  always_comb begin
    cnt_d = cnt_q;
    if (changing) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_sync_q <= '0;
      f_sync_q <= '0;
      cnt_q    <= '0;
    end else begin
      t_sync_q <= {t_sync_q[SYNC_STAGES-2:0], rail_t};
      f_sync_q <= {f_sync_q[SYNC_STAGES-2:0], rail_f};
      cnt_q    <= cnt_d;
    end
  end

  assign code   = {t_sync_q[SYNC_STAGES-1], f_sync_q[SYNC_STAGES-1]};
  assign stable = (cnt_q == CntMax);

endmodule

// File: rtl/mem_rw_strobe_ctrl.sv
// Turns each filtered DATA wavefront on the RW dual-rail pair into one level req/ack memory
// transaction, returns the NCL completion acknowledge and flags protocol/timeout errors.
module mem_rw_strobe_ctrl
  import mem_ncl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic RW_t,
  input  logic RW_f,
  output logic ko,
  output logic mem_req,
  output logic mem_we,
  input  logic mem_ack,
  input  logic err_clr,
  output logic err,
  output logic busy
);

  localparam int unsigned TimW = $clog2(ACK_TIMEOUT);
  localparam logic [TimW-1:0] TimMax = TimW'(ACK_TIMEOUT - 1);

  rail_code_t      code;
  logic            stable;
  state_t          state_q, state_d;
  logic [TimW-1:0] tcnt_q, tcnt_d;
  logic            we_d;
  logic            err_set;
  logic            null_idle;

  dual_rail_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .rail_t(RW_t),
    .rail_f(RW_f),
    .code  (code),
    .stable(stable)
  );

  assign null_idle = stable && (code == RAIL_NULL) && !mem_ack;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    we_d    = mem_we;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (stable && (code == RAIL_DATA0 || code == RAIL_DATA1)) begin
          state_d = StReq;
          we_d    = (code == RAIL_DATA1);
        end else if (stable && code == RAIL_ILLEGAL) begin
          state_d = StError;
          err_set = 1'b1;
        end
      end
      StReq: begin
        // Ack takes priority over an expiring timeout on the same edge.
        if (mem_ack) begin
          state_d = StDone;
        end else if (tcnt_q == TimMax) begin
          state_d = StError;
          err_set = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TimW'(1);
        end
      end
      StDone: begin
        if (null_idle) begin
          state_d = StIdle;
        end else if (stable && code == RAIL_ILLEGAL) begin
          state_d = StError;
          err_set = 1'b1;
        end
      end
      StError: begin
        if (null_idle) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      mem_we  <= 1'b0;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      ko      <= 1'b1;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      mem_we  <= we_d;
      mem_req <= (state_d == StReq);
      busy    <= (state_d != StIdle);
      // ko follows the state one edge late, so it drops on the edge after the ack is seen.
      ko      <= !(state_q == StDone || state_q == StError);
      err     <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_mem_rw_strobe_ctrl.sv
// Directed bench for mem_rw_strobe_ctrl with a rule-level reference model checked every cycle.
module tb_mem_rw_strobe_ctrl;

  localparam int SYNC   = 2;
  localparam int STABLE = 2;
  localparam int TMO    = 16;
  localparam int H      = SYNC + STABLE;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  logic clk = 1'b0;
  logic rst;
  logic rw_t, rw_f;
  logic ko, mem_req, mem_we, mem_ack, err_clr, err, busy;
  logic ack_auto, ack_man;
  logic [1:0] ack_pipe = 2'b00;

  int vectors    = 0;
  int miscompares = 0;
  int req_rises  = 0;
  int base;

  // reference model state
  logic [1:0] h [H];
  int   m_phase, m_prev, m_tcnt;
  logic m_we, m_err, m_ko, m_set, m_stable;
  logic [1:0] m_code;

  assign mem_ack = ack_auto ? ack_pipe[1] : ack_man;

  mem_rw_strobe_ctrl #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .ACK_TIMEOUT  (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .RW_t   (rw_t),
    .RW_f   (rw_f),
    .ko     (ko),
    .mem_req(mem_req),
    .mem_we (mem_we),
    .mem_ack(mem_ack),
    .err_clr(err_clr),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ack_pipe <= {ack_pipe[0], mem_req};

  always @(posedge mem_req) req_rises++;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a code counts as stable when the last STABLE samples seen through the
  // SYNC-deep synchronizer all agree; transitions follow the controller's rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < H; i++) h[i] = 2'b00;
      m_phase = P_IDLE;
      m_tcnt  = 0;
      m_we    = 1'b0;
      m_err   = 1'b0;
      m_ko    = 1'b1;
    end else begin
      for (int i = H - 1; i > 0; i--) h[i] = h[i-1];
      h[0] = {rw_t, rw_f};
      m_code   = h[SYNC];
      m_stable = 1'b1;
      for (int i = 1; i < STABLE; i++) if (h[SYNC+i] != m_code) m_stable = 1'b0;
      m_prev = m_phase;
      m_set  = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (m_stable && (m_code == 2'b01 || m_code == 2'b10)) begin
            m_phase = P_REQ;
            m_we    = (m_code == 2'b10);
            m_tcnt  = 0;
          end else if (m_stable && m_code == 2'b11) begin
            m_phase = P_ERR;
            m_set   = 1'b1;
          end
        end
        P_REQ: begin
          if (mem_ack) m_phase = P_DONE;
          else if (m_tcnt == TMO - 1) begin
            m_phase = P_ERR;
            m_set   = 1'b1;
          end else m_tcnt++;
        end
        P_DONE: begin
          if (m_stable && m_code == 2'b00 && !mem_ack) m_phase = P_IDLE;
          else if (m_stable && m_code == 2'b11) begin
            m_phase = P_ERR;
            m_set   = 1'b1;
          end
        end
        default: begin
          if (m_stable && m_code == 2'b00 && !mem_ack) m_phase = P_IDLE;
        end
      endcase
      if (m_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_ko = !(m_prev == P_DONE || m_prev == P_ERR);
    end
  end

  always @(negedge clk) begin
    check("cmp_mem_req", mem_req, int'(m_phase == P_REQ));
    check("cmp_busy", busy, int'(m_phase != P_IDLE));
    check("cmp_mem_we", mem_we, m_we);
    check("cmp_err", err, m_err);
    check("cmp_ko", ko, m_ko);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input int limit);
    int n = 0;
    while (mem_req !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, mem_req, 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (!(busy === 1'b0 && ko === 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy === 1'b0 && ko === 1'b1), 1);
    #1;
  endtask

  initial begin
    rst = 1'b1; rw_t = 1'b0; rw_f = 1'b0;
    ack_auto = 1'b1; ack_man = 1'b0; err_clr = 1'b0;
    step(2);
    check("reset_ko", ko, 1);
    check("reset_req", mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);

    // Read: rails change before edge 1, ack follows mem_req two cycles later.
    rst = 1'b0; rw_t = 1'b0; rw_f = 1'b1;
    repeat (3) @(negedge clk);
    check("read_req_edge3", mem_req, 0);
    @(negedge clk);
    check("read_req_edge4", mem_req, 1);
    check("read_we_edge4", mem_we, 0);
    check("read_busy_edge4", busy, 1);
    @(negedge clk);
    check("read_req_edge5", mem_req, 1);
    @(negedge clk);
    check("read_req_edge6", mem_req, 0);
    check("read_ko_edge6", ko, 1);
    @(negedge clk);
    check("read_ko_edge7", ko, 0);
    #1 rw_t = 1'b0; rw_f = 1'b0;
    wait_idle("read_back_idle", 12);

    // Write: ack five cycles into the request.
    ack_auto = 1'b0;
    base = req_rises;
    rw_t = 1'b1; rw_f = 1'b0;
    wait_req("write_req", 10);
    check("write_we", mem_we, 1);
    step(5);
    ack_man = 1'b1;
    check("write_we_held", mem_we, 1);
    step(2);
    check("write_req_dropped", mem_req, 0);
    check("write_busy_done", busy, 1);
    rw_t = 1'b0; ack_man = 1'b0;
    wait_idle("write_back_idle", 12);
    check("write_one_pulse", req_rises - base, 1);

    // Glitch: a single-sample DATA0 must be filtered out.
    base = req_rises;
    rw_f = 1'b1;
    step(1);
    rw_f = 1'b0;
    step(8);
    check("glitch_no_req", req_rises - base, 0);
    check("glitch_idle", busy, 0);

    // Illegal code, then recovery and explicit clear.
    rw_t = 1'b1; rw_f = 1'b1;
    step(6);
    check("illegal_err", err, 1);
    check("illegal_ko", ko, 0);
    rw_t = 1'b0; rw_f = 1'b0;
    wait_idle("illegal_back_idle", 12);
    check("illegal_err_sticky", err, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("illegal_err_cleared", err, 0);

    // Timeout: sixteen cycles in REQ; clear on the setting edge loses.
    rw_f = 1'b1;
    wait_req("tmo_req", 10);
    repeat (15) @(negedge clk);
    check("tmo_req_at_15", mem_req, 1);
    #1 err_clr = 1'b1;
    @(negedge clk);
    check("tmo_req_at_16", mem_req, 0);
    check("tmo_err_set_wins", err, 1);
    check("tmo_busy", busy, 1);
    #1 err_clr = 1'b0; rw_f = 1'b0;
    wait_idle("tmo_back_idle", 12);

    // Asynchronous reset in the middle of a write request, with err still set.
    rw_t = 1'b1;
    wait_req("rst_req", 10);
    check("rst_pre_we", mem_we, 1);
    check("rst_pre_err", err, 1);
    #3 rst = 1'b1;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_we", mem_we, 0);
    check("rst_async_err", err, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_ko", ko, 1);
    rw_t = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);

    // DATA0 then DATA1 without NULL in between: only one transaction.
    ack_auto = 1'b1;
    base = req_rises;
    rw_f = 1'b1;
    wait_req("dd_req", 10);
    step(4);
    check("dd_ko_low", ko, 0);
    rw_t = 1'b1; rw_f = 1'b0;
    step(12);
    check("dd_one_pulse", req_rises - base, 1);
    check("dd_stuck_done", busy, 1);
    rw_t = 1'b0;
    wait_idle("dd_back_idle", 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
